// File: rtl/pkt_pkg.sv
// Shared types, field layout and byte-count helpers for the packet length path.
package pkt_pkg;

    localparam int unsigned LEN_W             = 16;
    localparam int unsigned STAT_W            = 34;
    localparam int unsigned STAT_HDR_LEN_LSB  = 0;
    localparam int unsigned STAT_MEAS_LSB     = 16;
    localparam int unsigned STAT_MISMATCH_BIT = 32;
    localparam int unsigned STAT_HDR_ERR_BIT  = 33;
    localparam int unsigned KEEP_MAX_W        = 64;
    localparam int unsigned POP_W             = 7;

    typedef enum logic [0:0] {
        S_HEADER  = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    typedef struct packed {
        logic              hdr_err;
        logic              len_mismatch;
        logic [LEN_W-1:0]  measured_len;
        logic [LEN_W-1:0]  header_len;
    } stat_t;

    // Number of set byte enables; narrower keeps are zero-extended by the caller.
    function automatic logic [POP_W-1:0] popcount(input logic [KEEP_MAX_W-1:0] keep);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(KEEP_MAX_W); i++) begin
            n = n + POP_W'(keep[i]);
        end
        return n;
    endfunction

    // Length plus byte count, clamped at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_add_len(input logic [LEN_W-1:0] a,
                                                     input logic [POP_W-1:0] b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + (LEN_W+1)'(b);
        return s[LEN_W] ? '1 : s[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/packet_length_checker_if.sv
// AXI-Stream data channel with byte enables.
interface packet_length_checker_if #(
    parameter int unsigned DW = 128
);
    localparam int unsigned KW = DW / 8;

    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/pkt_byte_counter.sv
// Saturating payload byte accumulator for one packet.
module pkt_byte_counter
    import pkt_pkg::*;
#(
    parameter int unsigned KW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KW-1:0]    keep,
    input  logic             accept,
    input  logic             last,
    input  logic             clear,
    output logic [LEN_W-1:0] acc,
    output logic [LEN_W-1:0] measured_len_c
);

    // Length including the beat currently being accepted.
    assign measured_len_c = sat_add_len(acc, popcount(KEEP_MAX_W'(keep)));

    // Accumulate accepted beats; the closing beat leaves the counter empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (accept) begin
            acc <= last ? '0 : measured_len_c;
        end
    end

endmodule

// File: rtl/packet_length_checker.sv
// Strips the length header, forwards the payload and reports measured vs header length.
module packet_length_checker
    import pkt_pkg::*;
#(
    parameter int unsigned DW      = 128,
    parameter logic [15:0] MAX_LEN = 16'd16384,
    parameter int unsigned CW      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    packet_length_checker_if.slave   axis_in,
    packet_length_checker_if.master  axis_out,
    output logic [STAT_W-1:0]        stat_tdata,
    output logic                     stat_tvalid,
    input  logic                     stat_tready,
    output logic [CW-1:0]            pkt_count,
    output logic [CW-1:0]            err_count
);

    localparam int unsigned KW = DW / 8;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] hdr_len_q;
    logic             hdr_err_q;
    logic [LEN_W-1:0] acc;
    logic [LEN_W-1:0] measured_len_c;
    logic             hdr_ready_c;
    logic             hdr_accept_c;
    logic             pay_accept_c;
    logic             last_accept_c;
    logic             mismatch_c;
    logic             pkt_err_c;
    stat_t            stat_rec_c;

    // A new header waits until any pending status record is taken.
    assign hdr_ready_c   = ~stat_tvalid | stat_tready;
    assign hdr_accept_c  = (state_q == S_HEADER) & axis_in.tvalid & hdr_ready_c;
    assign pay_accept_c  = (state_q == S_PAYLOAD) & axis_in.tvalid & axis_out.tready;
    assign last_accept_c = pay_accept_c & axis_in.tlast;
    assign mismatch_c    = (measured_len_c != hdr_len_q);
    assign pkt_err_c     = hdr_err_q | mismatch_c;
    assign stat_rec_c    = '{hdr_err:      hdr_err_q,
                             len_mismatch: mismatch_c,
                             measured_len: measured_len_c,
                             header_len:   hdr_len_q};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stream steering: header is swallowed, payload passes straight through.
    always_comb begin
        state_d         = state_q;
        axis_in.tready  = 1'b0;
        axis_out.tvalid = 1'b0;
        axis_out.tdata  = axis_in.tdata;
        axis_out.tkeep  = axis_in.tkeep;
        axis_out.tlast  = axis_in.tlast;
        case (state_q)
            S_HEADER: begin
                axis_in.tready = hdr_ready_c;
                if (axis_in.tvalid && hdr_ready_c) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                axis_out.tvalid = axis_in.tvalid;
                axis_in.tready  = axis_out.tready;
                if (axis_in.tvalid && axis_out.tready && axis_in.tlast) begin
                    state_d = S_HEADER;
                end
            end
            default: state_d = S_HEADER;
        endcase
    end

    // Capture the header length and its legality.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_len_q <= '0;
            hdr_err_q <= 1'b0;
        end else if (hdr_accept_c) begin
            hdr_len_q <= axis_in.tdata[LEN_W-1:0];
            hdr_err_q <= (axis_in.tdata[LEN_W-1:0] == '0) |
                         (axis_in.tdata[LEN_W-1:0] > MAX_LEN);
        end
    end

    pkt_byte_counter #(
        .KW (KW)
    ) u_byte_counter (
        .clk            (clk),
        .reset          (reset),
        .keep           (axis_in.tkeep),
        .accept         (pay_accept_c),
        .last           (axis_in.tlast),
        .clear          (hdr_accept_c),
        .acc            (acc),
        .measured_len_c (measured_len_c)
    );

    // Status record: a new record takes priority over consumption of the old one.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_tvalid <= 1'b0;
            stat_tdata  <= '0;
        end else if (last_accept_c) begin
            stat_tvalid <= 1'b1;
            stat_tdata  <= stat_rec_c;
        end else if (stat_tready) begin
            stat_tvalid <= 1'b0;
        end
    end

    // Saturating packet and error counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count <= '0;
            err_count <= '0;
        end else if (last_accept_c) begin
            if (pkt_count != '1) begin
                pkt_count <= pkt_count + CW'(1);
            end
            if (pkt_err_c && (err_count != '1)) begin
                err_count <= err_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_packet_length_checker.sv
// Scoreboard bench for packet_length_checker: payload beats and status records are predicted as stimulus is driven.
module tb_packet_length_checker;
    import pkt_pkg::*;

    localparam int unsigned DW = 128;
    localparam int unsigned KW = 16;
    localparam int unsigned CW = 32;
    localparam logic [15:0] MAX_LEN = 16'd16384;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stat_tready = 1'b1;
    logic [STAT_W-1:0] stat_tdata;
    logic              stat_tvalid;
    logic [CW-1:0]     pkt_count;
    logic [CW-1:0]     err_count;

    packet_length_checker_if #(.DW(DW)) in_if ();
    packet_length_checker_if #(.DW(DW)) out_if ();

    packet_length_checker #(
        .DW      (DW),
        .MAX_LEN (MAX_LEN),
        .CW      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .axis_in     (in_if.slave),
        .axis_out    (out_if.master),
        .stat_tdata  (stat_tdata),
        .stat_tvalid (stat_tvalid),
        .stat_tready (stat_tready),
        .pkt_count   (pkt_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    beat_t             beat_q[$];
    logic [STAT_W-1:0] stat_q[$];
    beat_t             mon_beat;
    logic [STAT_W-1:0] mon_stat;
    int checks = 0;
    int failures = 0;
    int out_beats = 0;
    int exp_pkt = 0;
    int exp_err = 0;
    int rdy_mode = 0;

    // Downstream ready: always high, or a coin flip each cycle.
    always @(posedge clk) begin
        #1;
        out_if.tready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output beat scoreboard.
    always @(negedge clk) begin
        if (!reset && out_if.tvalid && out_if.tready) begin
            out_beats++;
            checks++;
            if (beat_q.size() == 0) begin
                failures++;
                $display("FAIL out_beat_unexpected: got data=%h keep=%h last=%b, required no beat",
                         out_if.tdata, out_if.tkeep, out_if.tlast);
            end else begin
                mon_beat = beat_q.pop_front();
                if ({out_if.tdata, out_if.tkeep, out_if.tlast} !== mon_beat) begin
                    failures++;
                    $display("FAIL out_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                             out_if.tdata, out_if.tkeep, out_if.tlast,
                             mon_beat.data, mon_beat.keep, mon_beat.last);
                end
            end
        end
    end

    // Status record scoreboard.
    always @(negedge clk) begin
        if (!reset && stat_tvalid && stat_tready) begin
            checks++;
            if (stat_q.size() == 0) begin
                failures++;
                $display("FAIL status_unexpected: got %h, required no record", stat_tdata);
            end else begin
                mon_stat = stat_q.pop_front();
                if (stat_tdata !== mon_stat) begin
                    failures++;
                    $display("FAIL status: got %h, required %h", stat_tdata, mon_stat);
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input bit is_hdr);
        int  waited;
        bit  done;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tlast  = l;
        in_if.tvalid = 1'b1;
        if (!is_hdr) beat_q.push_back({d, k, l});
        waited = 0;
        done   = 0;
        while (!done) begin
            @(negedge clk);
            if (in_if.tready) begin
                done = 1;
            end else if (waited >= 200) begin
                checks++;
                failures++;
                $display("FAIL send_beat_timeout: tready=%b after %0d cycles, required 1", in_if.tready, waited);
                done = 1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] hdr, input int nb, input logic [KW-1:0] last_keep);
        int          meas;
        logic [15:0] meas16;
        logic        herr;
        logic        mm;
        meas   = (nb - 1) * 16 + $countones(last_keep);
        meas16 = (meas > 65535) ? 16'hFFFF : 16'(meas);
        herr   = (hdr == 16'h0000) || (hdr > MAX_LEN);
        mm     = (meas16 != hdr);
        stat_q.push_back({herr, mm, meas16, hdr});
        exp_pkt++;
        if (herr || mm) exp_err++;
        send_beat({$urandom, $urandom, $urandom, 16'($urandom), hdr}, KW'($urandom), 1'($urandom), 1);
        for (int i = 0; i < nb; i++) begin
            send_beat({$urandom, $urandom, $urandom, $urandom},
                      (i == nb - 1) ? last_keep : {KW{1'b1}}, (i == nb - 1), 0);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tkeep  = '0;
        in_if.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stat_tvalid !== 1'b0 || stat_tdata !== '0) begin
            failures++;
            $display("FAIL reset_status: got valid=%b data=%h, required 0/0", stat_tvalid, stat_tdata);
        end
        checks++;
        if (pkt_count !== '0 || err_count !== '0) begin
            failures++;
            $display("FAIL reset_counters: got pkt=%0d err=%0d, required 0/0", pkt_count, err_count);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake: got out_valid=%b in_ready=%b, required 0/1", out_if.tvalid, in_if.tready);
        end
    endtask

    task automatic test_exact();
        int b0;
        b0 = out_beats;
        send_pkt(16'h0023, 3, 16'h0007);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_beats - b0 != 3) begin
            failures++;
            $display("FAIL exact_beats: got %0d output beats, required 3", out_beats - b0);
        end
        checks++;
        if (stat_tdata !== {1'b0, 1'b0, 16'h0023, 16'h0023}) begin
            failures++;
            $display("FAIL exact_status: got %h, required %h", stat_tdata, {1'b0, 1'b0, 16'h0023, 16'h0023});
        end
        checks++;
        if (pkt_count !== CW'(1) || err_count !== CW'(0)) begin
            failures++;
            $display("FAIL exact_counters: got pkt=%0d err=%0d, required 1/0", pkt_count, err_count);
        end
    endtask

    task automatic test_mismatch();
        send_pkt(16'h0020, 2, 16'h00FF);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stat_tdata !== {1'b0, 1'b1, 16'h0018, 16'h0020}) begin
            failures++;
            $display("FAIL mismatch_status: got %h, required %h", stat_tdata, {1'b0, 1'b1, 16'h0018, 16'h0020});
        end
        checks++;
        if (err_count !== CW'(1) || beat_q.size() != 0) begin
            failures++;
            $display("FAIL mismatch_err: got err=%0d pending_beats=%0d, required 1/0", err_count, beat_q.size());
        end
    endtask

    task automatic test_hdr_err();
        logic [15:0] hdrs [3];
        logic [33:0] exps [3];
        int e0;
        hdrs[0] = 16'h0000; exps[0] = {1'b1, 1'b1, 16'h0010, 16'h0000};
        hdrs[1] = 16'h4001; exps[1] = {1'b1, 1'b1, 16'h0010, 16'h4001};
        hdrs[2] = 16'h4000; exps[2] = {1'b0, 1'b1, 16'h0010, 16'h4000};
        for (int i = 0; i < 3; i++) begin
            e0 = exp_err;
            send_pkt(hdrs[i], 1, 16'hFFFF);
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (stat_tdata !== exps[i]) begin
                failures++;
                $display("FAIL hdr_err_status[%0d]: got %h, required %h", i, stat_tdata, exps[i]);
            end
            checks++;
            if (err_count !== CW'(e0 + 1)) begin
                failures++;
                $display("FAIL hdr_err_count[%0d]: got %0d, required %0d", i, err_count, e0 + 1);
            end
        end
    endtask

    task automatic test_status_backpressure();
        stat_tready = 1'b0;
        send_pkt(16'h0010, 1, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stat_tvalid !== 1'b1 || stat_tdata !== {1'b0, 1'b0, 16'h0010, 16'h0010}) begin
            failures++;
            $display("FAIL bp_status_held: got valid=%b data=%h, required 1/%h",
                     stat_tvalid, stat_tdata, {1'b0, 1'b0, 16'h0010, 16'h0010});
        end
        stat_q.push_back({1'b0, 1'b0, 16'h0020, 16'h0020});
        exp_pkt++;
        in_if.tdata  = {96'h0, 16'hABCD, 16'h0020};
        in_if.tkeep  = '1;
        in_if.tlast  = 1'b0;
        in_if.tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_if.tready !== 1'b0) begin
                failures++;
                $display("FAIL bp_header_gated[%0d]: got tready=%b, required 0", i, in_if.tready);
            end
            @(posedge clk);
            #1;
        end
        stat_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL bp_header_release: got tready=%b, required 1", in_if.tready);
        end
        @(posedge clk);
        #1;
        in_if.tvalid = 1'b0;
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0, 0);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stat_q.size() != 0 || pkt_count !== CW'(exp_pkt)) begin
            failures++;
            $display("FAIL bp_no_loss: got pending_status=%0d pkt=%0d, required 0/%0d",
                     stat_q.size(), pkt_count, exp_pkt);
        end
    endtask

    task automatic test_random();
        int          nb;
        logic [15:0] lk;
        logic [15:0] hdr;
        rdy_mode = 1;
        for (int p = 0; p < 100; p++) begin
            nb = $urandom_range(1, 6);
            lk = 16'($urandom);
            if (nb == 1 && lk == 16'h0000) lk = 16'h0001;
            hdr = 16'((nb - 1) * 16 + $countones(lk));
            send_pkt(hdr, nb, lk);
        end
        rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (pkt_count !== CW'(exp_pkt) || err_count !== CW'(exp_err)) begin
            failures++;
            $display("FAIL random_counters: got pkt=%0d err=%0d, required %0d/%0d",
                     pkt_count, err_count, exp_pkt, exp_err);
        end
        checks++;
        if (beat_q.size() != 0 || stat_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain: got pending beats=%0d status=%0d, required 0/0",
                     beat_q.size(), stat_q.size());
        end
    endtask

    task automatic test_reset_mid();
        send_beat({96'h0, 16'h5555, 16'h0030}, 16'hFFFF, 1'b0, 1);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0, 0);
        in_if.tdata  = {$urandom, $urandom, $urandom, $urandom};
        in_if.tkeep  = 16'hFFFF;
        in_if.tlast  = 1'b0;
        in_if.tvalid = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_if.tvalid !== 1'b0 || stat_tvalid !== 1'b0 || stat_tdata !== '0 ||
            pkt_count !== '0 || err_count !== '0) begin
            failures++;
            $display("FAIL reset_mid_state: got out_valid=%b stat_valid=%b stat=%h pkt=%0d err=%0d, required all 0",
                     out_if.tvalid, stat_tvalid, stat_tdata, pkt_count, err_count);
        end
        reset        = 1'b0;
        in_if.tvalid = 1'b0;
        exp_pkt      = 0;
        exp_err      = 0;
        @(posedge clk);
        #1;
        send_pkt(16'h0010, 1, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stat_tdata !== {1'b0, 1'b0, 16'h0010, 16'h0010} || pkt_count !== CW'(1) || err_count !== CW'(0)) begin
            failures++;
            $display("FAIL reset_mid_next: got stat=%h pkt=%0d err=%0d, required %h/1/0",
                     stat_tdata, pkt_count, err_count, {1'b0, 1'b0, 16'h0010, 16'h0010});
        end
        checks++;
        if (beat_q.size() != 0 || stat_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_drain: got pending beats=%0d status=%0d, required 0/0",
                     beat_q.size(), stat_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_mismatch();
        test_hdr_err();
        test_status_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
